// File: rtl/ctrl_sched_pkg.sv
// ctrl_sched shared types and constants.
// Parameter slot addresses match the packing order of tgt/cur.
package ctrl_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    WRITE = 2'd2
  } state_e;

  localparam int N_PAR_DEF = 7;

  localparam logic [2:0] ADDR_A8     = 3'd0;
  localparam logic [2:0] ADDR_A5     = 3'd1;
  localparam logic [2:0] ADDR_A4     = 3'd2;
  localparam logic [2:0] ADDR_BLEND  = 3'd3;
  localparam logic [2:0] ADDR_DELAY  = 3'd4;
  localparam logic [2:0] ADDR_FEEDBK = 3'd5;
  localparam logic [2:0] ADDR_GAIN   = 3'd6;

endpackage

// File: rtl/ctrl_slew_step.sv
// Next applied value for one parameter, from its current and target values.
// CTRL_SCHED_SLEW_EN: bounded step toward target; otherwise a direct jump.
module ctrl_slew_step #(
  parameter int BITS = 8,
  parameter int STEP = 4
) (
  input  logic [BITS-1:0] cur_i,
  input  logic [BITS-1:0] snap_i,
  output logic [BITS-1:0] next_o
);

`ifdef CTRL_SCHED_SLEW_EN
  localparam logic [BITS-1:0] STEP_V = BITS'(STEP);

  logic [BITS-1:0] up_diff;
  logic [BITS-1:0] dn_diff;

  // Clamp the move to STEP; a short remaining distance lands exactly on snap.
  always_comb begin
    up_diff = snap_i - cur_i;
    dn_diff = cur_i - snap_i;
    next_o  = snap_i;
    if (snap_i > cur_i) begin
      if (up_diff > STEP_V) next_o = cur_i + STEP_V;
    end else if (snap_i < cur_i) begin
      if (dn_diff > STEP_V) next_o = cur_i - STEP_V;
    end
  end
`else
  logic unused_cur;

  assign unused_cur = ^{cur_i, BITS'(STEP)};
  assign next_o     = snap_i;
`endif

endmodule

// File: rtl/ctrl_sched.sv
// Parameter update scheduler: snapshot targets per sample tick, issue slewed writes.
// Optional macro CTRL_SCHED_SLEW_EN enables step limiting in ctrl_slew_step.
module ctrl_sched
  import ctrl_sched_pkg::*;
#(
  parameter int N_PAR = N_PAR_DEF,
  parameter int BITS  = 8,
  parameter int STEP  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_PAR*BITS-1:0] tgt,
  input  logic                  tgt_stb,
  input  logic                  sample_tick,
  output logic [2:0]            wr_addr,
  output logic [BITS-1:0]       wr_data,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [N_PAR*BITS-1:0] cur,
  output logic                  busy,
  output logic                  overrun,
  input  logic                  overrun_clr
);

  localparam logic [2:0] IDX_LAST = 3'(N_PAR - 1);

  state_e                state_q, state_d;
  logic [2:0]            idx_q, idx_d;
  logic [N_PAR*BITS-1:0] pend_q, pend_d;
  logic [N_PAR*BITS-1:0] snap_q, snap_d;
  logic [N_PAR*BITS-1:0] cur_q, cur_d;
  logic [2:0]            wr_addr_q, wr_addr_d;
  logic [BITS-1:0]       wr_data_q, wr_data_d;
  logic                  wr_valid_q, wr_valid_d;
  logic                  ovr_q, ovr_d;

  logic [BITS-1:0]       cur_sel;
  logic [BITS-1:0]       snap_sel;
  logic [BITS-1:0]       next_val;

  assign cur_sel  = cur_q[idx_q*BITS +: BITS];
  assign snap_sel = snap_q[idx_q*BITS +: BITS];

  ctrl_slew_step #(
    .BITS (BITS),
    .STEP (STEP)
  ) u_step (
    .cur_i  (cur_sel),
    .snap_i (snap_sel),
    .next_o (next_val)
  );

  // State and datapath registers; reset also kills any pending write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      pend_q     <= '0;
      snap_q     <= '0;
      cur_q      <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      snap_q     <= snap_d;
      cur_q      <= cur_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_valid_q <= wr_valid_d;
      ovr_q      <= ovr_d;
    end
  end

  // Sweep sequencing: scan each slot, write the changed ones one at a time.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pend_d     = pend_q;
    snap_d     = snap_q;
    cur_d      = cur_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_valid_d = wr_valid_q;
    ovr_d      = ovr_q;

    if (tgt_stb) pend_d = tgt;

    if (sample_tick && state_q != IDLE) begin
      ovr_d = 1'b1;
    end else if (overrun_clr) begin
      ovr_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (sample_tick) begin
          snap_d  = tgt_stb ? tgt : pend_q;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (cur_sel == snap_sel) begin
          if (idx_q == IDX_LAST) begin
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          wr_addr_d  = idx_q;
          wr_data_d  = next_val;
          wr_valid_d = 1'b1;
          state_d    = WRITE;
        end
      end
      WRITE: begin
        if (wr_valid_q && wr_ready) begin
          cur_d[idx_q*BITS +: BITS] = wr_data_q;
          wr_valid_d = 1'b0;
          if (idx_q == IDX_LAST) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = SCAN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_valid = wr_valid_q;
  assign cur      = cur_q;
  assign busy     = (state_q != IDLE);
  assign overrun  = ovr_q;

endmodule

// File: tb/tb_ctrl_sched.sv
// Directed bench for ctrl_sched; expectations follow CTRL_SCHED_SLEW_EN.
// Inputs change 1 time unit after posedge; outputs are logged at negedge.
module tb_ctrl_sched;
  import ctrl_sched_pkg::*;

  localparam int N = 7;
  localparam int B = 8;

`ifdef CTRL_SCHED_SLEW_EN
  localparam bit SLEW = 1'b1;
`else
  localparam bit SLEW = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [N*B-1:0] tgt;
  logic         tgt_stb;
  logic         sample_tick;
  logic [2:0]   wr_addr;
  logic [B-1:0] wr_data;
  logic         wr_valid;
  logic         wr_ready;
  logic [N*B-1:0] cur;
  logic         busy;
  logic         overrun;
  logic         overrun_clr;

  ctrl_sched dut (
    .clk         (clk),
    .reset       (reset),
    .tgt         (tgt),
    .tgt_stb     (tgt_stb),
    .sample_tick (sample_tick),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .cur         (cur),
    .busy        (busy),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  always #10 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [2:0] wa[$];
  logic [7:0] wd[$];
  int busy_n = 0;
  int ws;

  always @(negedge clk) begin
    if (busy === 1'b1) busy_n++;
    if (wr_valid === 1'b1 && wr_ready === 1'b1) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
    end
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    tgt         = '0;
    tgt_stb     = 1'b0;
    sample_tick = 1'b0;
    wr_ready    = 1'b1;
    overrun_clr = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic load(input logic [N*B-1:0] v);
    tgt     = v;
    tgt_stb = 1'b1;
    cyc();
    tgt_stb = 1'b0;
  endtask

  task automatic sweep(output int nw, output int nb);
    int  w0;
    int  b0;
    bit  done;
    w0 = wa.size();
    b0 = busy_n;
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    tgt_stb     = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      cyc();
      if (!busy) done = 1'b1;
    end
    if (!done) check("sweep_timeout", {63'd0, busy}, 64'd0);
    ws = w0;
    nw = wa.size() - w0;
    nb = busy_n - b0;
  endtask

  task automatic wait_valid(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (wr_valid) seen = 1'b1;
      else cyc();
    end
    check(tag, {63'd0, wr_valid}, 64'd1);
  endtask

  logic [7:0] e1;
  logic [7:0] t2d[4];
  int         t2n[4];
  logic [2:0] a0;
  logic [7:0] d0;
  bit         stable;
  bit         fin;
  int         nw;
  int         nb;

  initial begin
    // Reset state
    do_reset();
    check("rst_cur", cur, 0);
    check("rst_valid", wr_valid, 0);
    check("rst_addr", wr_addr, 0);
    check("rst_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_ovr", overrun, 0);

    // All seven targets 0x10
    e1 = SLEW ? 8'h04 : 8'h10;
    load({7{8'h10}});
    sweep(nw, nb);
    check("t1_nw", nw, 7);
    check("t1_busy", nb, 14);
    for (int i = 0; i < 7; i++) begin
      if (nw > i) begin
        check($sformatf("t1_addr%0d", i), wa[ws+i], i);
        check($sformatf("t1_data%0d", i), wd[ws+i], e1);
      end
    end
    check("t1_cur", cur, {7{e1}});

    // a8 ramp 0x00 -> 0x0A over four ticks
    if (SLEW) begin
      t2d = '{8'h04, 8'h08, 8'h0A, 8'h00};
      t2n = '{1, 1, 1, 0};
    end else begin
      t2d = '{8'h0A, 8'h00, 8'h00, 8'h00};
      t2n = '{1, 0, 0, 0};
    end
    do_reset();
    load({48'd0, 8'h0A});
    for (int t = 0; t < 4; t++) begin
      sweep(nw, nb);
      check($sformatf("t2_nw%0d", t), nw, t2n[t]);
      check($sformatf("t2_busy%0d", t), nb, t2n[t] != 0 ? 8 : 7);
      if (nw > 0 && t2n[t] != 0) begin
        check($sformatf("t2_addr%0d", t), wa[ws], ADDR_A8);
        check($sformatf("t2_data%0d", t), wd[ws], t2d[t]);
      end
    end
    check("t2_cur", cur, {48'd0, 8'h0A});

    // gain 0x02 -> 0x00: no wrap
    do_reset();
    load({8'h02, 48'd0});
    sweep(nw, nb);
    check("t3_cur_up", cur[55:48], 8'h02);
    load('0);
    sweep(nw, nb);
    check("t3_nw", nw, 1);
    if (nw > 0) begin
      check("t3_addr", wa[ws], ADDR_GAIN);
      check("t3_data", wd[ws], 8'h00);
    end
    check("t3_cur", cur, 0);

    // a5 0xFA -> 0xFF: top boundary without overshoot
    do_reset();
    load({40'd0, 8'hFA, 8'h00});
    fin = 1'b0;
    for (int t = 0; t < 80 && !fin; t++) begin
      sweep(nw, nb);
      if (cur[15:8] == 8'hFA) fin = 1'b1;
    end
    check("t4_reach", cur[15:8], 8'hFA);
    load({40'd0, 8'hFF, 8'h00});
    sweep(nw, nb);
    check("t4_nw1", nw, 1);
    if (nw > 0) begin
      check("t4_addr", wa[ws], ADDR_A5);
      check("t4_data1", wd[ws], SLEW ? 8'hFE : 8'hFF);
    end
    sweep(nw, nb);
    check("t4_nw2", nw, SLEW ? 1 : 0);
    check("t4_cur", cur, {40'd0, 8'hFF, 8'h00});

    // Stalled write, tick during sweep, overrun set-wins and clear
    do_reset();
    wr_ready = 1'b0;
    load({7{8'h10}});
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    wait_valid("t5_valid");
    a0 = wr_addr;
    d0 = wr_data;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        sample_tick = 1'b1;
        overrun_clr = 1'b1;
        tgt         = {7{8'h20}};
        tgt_stb     = 1'b1;
      end
      cyc();
      sample_tick = 1'b0;
      overrun_clr = 1'b0;
      tgt_stb     = 1'b0;
      if (wr_addr !== a0 || wr_data !== d0 || wr_valid !== 1'b1) stable = 1'b0;
    end
    check("t5_stable", stable, 1);
    check("t5_addr", a0, ADDR_A8);
    check("t5_data", d0, e1);
    check("t5_ovr_set", overrun, 1);
    wr_ready = 1'b1;
    fin = 1'b0;
    for (int k = 0; k < 50 && !fin; k++) begin
      cyc();
      if (!busy) fin = 1'b1;
    end
    check("t5_done", busy, 0);
    check("t5_cur", cur, {7{e1}});
    cyc();
    cyc();
    check("t5_dropped", busy, 0);
    check("t5_ovr_hold", overrun, 1);
    overrun_clr = 1'b1;
    cyc();
    overrun_clr = 1'b0;
    check("t5_ovr_clr", overrun, 0);
    sweep(nw, nb);
    check("t5_pend", cur[7:0], SLEW ? 8'h08 : 8'h20);

    // Strobe and tick in the same cycle
    do_reset();
    tgt     = {32'd0, 8'h80, 16'd0};
    tgt_stb = 1'b1;
    sweep(nw, nb);
    check("t6_nw", nw, 1);
    if (nw > 0) begin
      check("t6_addr", wa[ws], ADDR_A4);
      check("t6_data", wd[ws], SLEW ? 8'h04 : 8'h80);
    end

    // Reset asserted during WRITE
    do_reset();
    wr_ready = 1'b0;
    load({7{8'h10}});
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    wait_valid("t7_valid");
    #3;
    reset = 1'b1;
    #1;
    check("t7_valid_drop", wr_valid, 0);
    check("t7_busy", busy, 0);
    check("t7_cur", cur, 0);
    cyc();
    reset    = 1'b0;
    wr_ready = 1'b1;
    cyc();
    sweep(nw, nb);
    check("t7_pend_nw", nw, 0);
    check("t7_pend_busy", nb, 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
